// File: rtl/axis_wb_bridge.sv
// rtl/axis_wb_bridge.sv - byte-stream command decoder driving a single-beat Wishbone master
// Commands: A1 addr[4] data[4] (write) or A2 addr[4] (read); responses 5A [+4 data bytes] or EE.
module axis_wb_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [7:0]  OP_WRITE = 8'hA1;
  localparam logic [7:0]  OP_READ  = 8'hA2;
  localparam logic [7:0]  RSP_OK   = 8'h5A;
  localparam logic [7:0]  RSP_ERR  = 8'hEE;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    BUS   = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [15:0] tcnt;
  logic [31:0] resp_sr;
  logic [2:0]  resp_left;

  logic in_fire;
  logic out_fire;
  logic opcode_ok;
  logic last_byte;
  logic tmo;
  logic bus_end;
  logic bus_err;

  assign in_fire   = s_axis_tvalid & s_axis_tready;
  assign out_fire  = m_axis_tvalid & m_axis_tready;
  assign opcode_ok = (s_axis_tdata == OP_WRITE) || (s_axis_tdata == OP_READ);
  assign last_byte = (byte_cnt == 2'd3);
  assign tmo       = (tcnt == TMO_LAST);
  assign bus_end   = wb_ack_i | wb_err_i | tmo;
  // err wins over a simultaneous ack; a timeout only counts when the slave stayed silent
  assign bus_err   = wb_err_i | (tmo & ~wb_ack_i);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire && opcode_ok) state_nxt = ADDR;
      ADDR:    if (in_fire && last_byte) state_nxt = is_write ? WDATA : BUS;
      WDATA:   if (in_fire && last_byte) state_nxt = BUS;
      BUS:     if (bus_end) state_nxt = RESP;
      RESP:    if (out_fire && (resp_left == 3'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake and bus strobes are registered from the next state so they stay low during reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_sel_o      <= 4'h0;
      wb_adr_o      <= 32'h0;
      wb_dat_o      <= 32'h0;
      is_write      <= 1'b0;
      byte_cnt      <= 2'd0;
      tcnt          <= 16'd0;
      resp_sr       <= 32'h0;
      resp_left     <= 3'd0;
    end else begin
      s_axis_tready <= (state_nxt == IDLE) || (state_nxt == ADDR) || (state_nxt == WDATA);
      m_axis_tvalid <= (state_nxt == RESP);
      wb_cyc_o      <= (state_nxt == BUS);
      wb_stb_o      <= (state_nxt == BUS);
      wb_we_o       <= (state_nxt == BUS) && is_write;
      wb_sel_o      <= (state_nxt == BUS) ? 4'hF : 4'h0;
      tcnt          <= (state == BUS) ? tcnt + 16'd1 : 16'd0;
      case (state)
        IDLE: begin
          byte_cnt <= 2'd0;
          if (in_fire && opcode_ok) is_write <= (s_axis_tdata == OP_WRITE);
        end
        ADDR: begin
          if (in_fire) begin
            wb_adr_o <= {wb_adr_o[23:0], s_axis_tdata};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WDATA: begin
          if (in_fire) begin
            wb_dat_o <= {wb_dat_o[23:0], s_axis_tdata};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        BUS: begin
          if (bus_end) begin
            if (bus_err) begin
              m_axis_tdata <= RSP_ERR;
              resp_left    <= 3'd0;
            end else begin
              m_axis_tdata <= RSP_OK;
              resp_left    <= is_write ? 3'd0 : 3'd4;
              if (!is_write) resp_sr <= wb_dat_i;
            end
          end
        end
        RESP: begin
          if (out_fire && (resp_left != 3'd0)) begin
            m_axis_tdata <= resp_sr[31:24];
            resp_sr      <= {resp_sr[23:0], 8'h00};
            resp_left    <= resp_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_wb_bridge.sv
// tb/tb_axis_wb_bridge.sv - self-checking bench for axis_wb_bridge
// Table vectors, hand sequences for timeout/garbage/reset, and random transactions vs a response model.
module tb_axis_wb_bridge;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  axis_wb_bridge #(.TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model configuration and observations
  int          slv_lat = 0;
  bit          slv_ack = 1'b1;
  bit          slv_err = 1'b0;
  bit          slv_noack = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          wait_cnt = 0;
  int          bus_cycles = 0;
  int          n_cyc = 0;
  bit          cyc_prev = 1'b0;
  bit          unstable = 1'b0;
  int          t_stb = 0;
  int          t_ack = 0;
  logic [31:0] rec_adr, rec_dat;
  logic        rec_we;
  logic [3:0]  rec_sel;

  always @(negedge clk) begin
    if (i_rst) begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wait_cnt = 0; cyc_prev = 1'b0;
    end else begin
      if (wb_cyc_o) begin
        if (!cyc_prev) begin
          n_cyc++; t_stb = cyc_n;
          rec_adr = wb_adr_o; rec_dat = wb_dat_o; rec_we = wb_we_o; rec_sel = wb_sel_o;
        end else if (wb_adr_o !== rec_adr || wb_dat_o !== rec_dat || wb_we_o !== rec_we || wb_sel_o !== rec_sel)
          unstable = 1'b1;
        if (wb_stb_o !== 1'b1) unstable = 1'b1;
        bus_cycles++;
        if (!slv_noack && wait_cnt == slv_lat) begin
          wb_ack_i = slv_ack; wb_err_i = slv_err; wb_dat_i = slv_rdata; t_ack = cyc_n;
        end else begin
          wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
        end
        wait_cnt++;
      end else begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wait_cnt = 0;
      end
      cyc_prev = wb_cyc_o;
    end
  end

  // Response collector with optional random back-pressure
  logic [7:0] resp_q[$];
  bit         rdy_rand = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  bit         val_seen = 1'b0;
  int         t_val = 0;

  always @(negedge clk) begin
    if (i_rst) begin
      stall_prev = 1'b0;
      m_axis_tready = 1'b1;
    end else begin
      if (stall_prev) begin
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("stall_tdata", 64'(m_axis_tdata), 64'(stall_data));
      end
      m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid && !val_seen) begin val_seen = 1'b1; t_val = cyc_n; end
      if (m_axis_tvalid && m_axis_tready) resp_q.push_back(m_axis_tdata);
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
    end
  end

  int t_last = 0;

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_axis_tdata = b;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      vectors++; miscompares++;
      $display("FAIL send_bound: tready low for %0d cycles, required at most 999", n);
    end
    t_last = cyc_n;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  function automatic void model(input bit wr, input logic [31:0] rdata, input bit err, input bit noack,
                                output int len, output logic [39:0] bytes);
    if (noack || err) begin len = 1; bytes = {8'hEE, 32'h0}; end
    else if (wr)      begin len = 1; bytes = {8'h5A, 32'h0}; end
    else              begin len = 5; bytes = {8'h5A, rdata}; end
  endfunction

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, input bit ack, input bit err,
                         input bit noack, input bit rnd, input int exp_len, input logic [39:0] exp_b);
    int tl;
    int n = 0;
    resp_q.delete();
    val_seen = 1'b0; n_cyc = 0; bus_cycles = 0; unstable = 1'b0;
    slv_lat = lat; slv_ack = ack; slv_err = err; slv_noack = noack; slv_rdata = rdata;
    rdy_rand = rnd;
    send_byte(wr ? 8'hA1 : 8'hA2);
    for (int i = 0; i < 4; i++) send_byte(addr[31-8*i -: 8]);
    if (wr) for (int i = 0; i < 4; i++) send_byte(wdata[31-8*i -: 8]);
    tl = t_last;
    while (resp_q.size() < exp_len && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("resp_len", 64'(resp_q.size()), 64'(exp_len));
    for (int i = 0; i < exp_len; i++)
      if (i < resp_q.size()) check("resp_byte", 64'(resp_q[i]), 64'(exp_b[39-8*i -: 8]));
    check("bus_cycles_count", 64'(n_cyc), 64'd1);
    check("bus_adr", 64'(rec_adr), 64'(addr));
    check("bus_we", 64'(rec_we), 64'(wr));
    check("bus_sel", 64'(rec_sel), 64'hF);
    check("bus_stable", 64'(unstable), 64'd0);
    if (wr) check("bus_dat", 64'(rec_dat), 64'(wdata));
    check("stb_latency", 64'(t_stb - tl), 64'd1);
    if (noack) check("timeout_len", 64'(bus_cycles), 64'(TMO));
    else begin
      check("ack_to_valid", 64'(t_val - t_ack), 64'd1);
      check("cyc_len", 64'(bus_cycles), 64'(lat + 1));
    end
    rdy_rand = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    bit          ack;
    bit          err;
    int          exp_len;
    logic [39:0] exp_b;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish within 5 ms");
    $fatal(1);
  end

  initial begin
    int          len;
    logic [39:0] eb;
    bit          wr, err, ack;
    logic [31:0] a, d, r;
    int          lat, kind;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         3, 1'b1, 1'b0, 1, 40'h5A_0000_0000};
    tbl[1] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 0, 1'b1, 1'b0, 5, 40'h5A_1234_5678};
    tbl[2] = '{1'b1, 32'h0000_0004, 32'h0BAD_F00D, 32'h0,         1, 1'b0, 1'b1, 1, 40'hEE_0000_0000};
    tbl[3] = '{1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_0001, 2, 1'b1, 1'b1, 1, 40'hEE_0000_0000};
    tbl[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_0F0F, 5, 1'b1, 1'b0, 5, 40'h5A_A5A5_0F0F};
    tbl[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0,         0, 1'b1, 1'b0, 1, 40'h5A_0000_0000};

    repeat (3) @(negedge clk);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_cyc_stb_we", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
    check("rst_adr_dat", 64'({wb_adr_o, wb_dat_o}), 64'd0);
    check("rst_sel", 64'(wb_sel_o), 64'd0);
    i_rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", 64'(s_axis_tready), 64'd1);

    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].lat,
              tbl[i].ack, tbl[i].err, 1'b0, 1'b0, tbl[i].exp_len, tbl[i].exp_b);

    // Slave never answers: timeout abort
    run_txn(1'b0, 32'h0000_0040, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 40'hEE_0000_0000);

    // Non-opcode bytes are dropped silently
    resp_q.delete(); n_cyc = 0;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h42);
    repeat (6) @(negedge clk);
    check("garbage_no_resp", 64'(resp_q.size()), 64'd0);
    check("garbage_no_bus", 64'(n_cyc), 64'd0);
    run_txn(1'b0, 32'h0000_0044, 32'h0, 32'h8765_4321, 1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 40'h5A_8765_4321);

    // Reset while the bus cycle is open
    resp_q.delete(); slv_noack = 1'b1;
    send_byte(8'hA2);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    repeat (5) @(negedge clk);
    check("rst_bus_pre_cyc", 64'(wb_cyc_o), 64'd1);
    #2 i_rst = 1'b1;
    #1;
    check("rst_bus_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    check("rst_bus_tvalid", 64'(m_axis_tvalid), 64'd0);
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_bus_no_resp", 64'(resp_q.size()), 64'd0);
    check("rst_bus_idle_ready", 64'(s_axis_tready), 64'd1);
    run_txn(1'b1, 32'h0000_0100, 32'h1357_9BDF, 32'h0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 40'h5A_0000_0000);

    // Random transactions with random response back-pressure
    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = $urandom;
      d    = $urandom;
      r    = $urandom;
      lat  = $urandom_range(0, 6);
      kind = $urandom_range(0, 7);
      err  = (kind < 2);
      ack  = (kind != 0);
      model(wr, r, err, 1'b0, len, eb);
      run_txn(wr, a, d, r, lat, ack, err, 1'b0, 1'b1, len, eb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_wb_bridge.md
AXIS_WB_BRIDGE -- requirements
Module: axis_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of bus cycles without ack/err before a Wishbone cycle is aborted (range 1..65535).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port s_axis_tdata, input, 8 bits: command byte stream from the UART receiver.
REQ-005 SHALL have port s_axis_tvalid, input, 1 bit, and s_axis_tready, output, 1 bit: input-stream handshake.
REQ-006 SHALL have port m_axis_tdata, output, 8 bits: response byte stream to the UART transmitter.
REQ-007 SHALL have port m_axis_tvalid, output, 1 bit, and m_axis_tready, input, 1 bit: output-stream handshake.
REQ-008 SHALL have Wishbone master ports: wb_adr_o out 32; wb_dat_o out 32; wb_dat_i in 32; wb_we_o out 1; wb_sel_o out 4; wb_stb_o out 1; wb_cyc_o out 1; wb_ack_i in 1; wb_err_i in 1.

Function
REQ-009 SHALL treat a byte as transferred only on a clock edge where tvalid and tready are both high, on either stream.
REQ-010 SHALL implement states IDLE, ADDR, WDATA, BUS, RESP.
REQ-011 SHALL, in IDLE, hold s_axis_tready=1 and decode each accepted byte: 0xA1 = write, go to ADDR; 0xA2 = read, go to ADDR; any other byte is discarded and the state stays IDLE with no response.
REQ-012 SHALL, in ADDR, accept exactly 4 bytes MSB-first into the 32-bit address; after the 4th byte go to WDATA for a write, or to BUS for a read.
REQ-013 SHALL, in WDATA, accept exactly 4 bytes MSB-first into wb_dat_o, then go to BUS.
REQ-014 SHALL hold s_axis_tready=0 in BUS and RESP; input bytes are back-pressured, never dropped.
REQ-015 SHALL, on entry to BUS, assert wb_cyc_o=wb_stb_o=1 and wb_sel_o=4'hF, with wb_we_o=1 for a write and 0 for a read, holding wb_adr_o, wb_dat_o and wb_we_o stable until the cycle ends.
REQ-016 SHALL end the cycle on the first edge with wb_ack_i=1 or wb_err_i=1, deasserting cyc/stb on the following cycle (single-beat classic cycle, no pipelining); for a read ending on ack, it SHALL capture wb_dat_i on that edge.
REQ-017 SHALL, if both wb_ack_i and wb_err_i are high on the same edge, treat the event as an error.
REQ-018 SHALL use a 16-bit timeout counter that clears on BUS entry and increments each BUS cycle; when it reaches TIMEOUT with no ack/err, the cycle SHALL be aborted as an error.
REQ-019 SHALL produce the following response sequences in RESP: write-ok = 0x5A; read-ok = 0x5A followed by 4 data bytes MSB-first; error (err or timeout) = 0xEE only.
REQ-020 SHALL drive m_axis_tvalid=1 throughout RESP and hold m_axis_tdata stable until accepted; it SHALL advance one byte per accepted transfer and return to IDLE after the last byte is accepted.
REQ-021 SHALL keep m_axis_tvalid=0 outside RESP.
REQ-022 SHALL add latency of 1 cycle from the last command byte accepted to stb asserted, and 1 cycle from ack to the first response byte valid.
REQ-023 SHALL keep the command flow strictly serialized: no new command is accepted until the response completes.

Reset
REQ-024 SHALL, while i_rst=1, force: state=IDLE; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0; wb_cyc_o=wb_stb_o=wb_we_o=0; wb_adr_o=wb_dat_o=0; wb_sel_o=0; counters=0.
REQ-025 SHALL, on reset asserted mid-command or mid-bus-cycle, abandon the transaction immediately without a response, and resume in IDLE on the first edge after release.

Verification
REQ-026 SHALL be verified by: bytes A1 00 00 00 10 DE AD BE EF, slave acks after 3 cycles -> one cycle adr=0x10, dat=0xDEADBEEF, we=1, sel=F; response 5A.
REQ-027 SHALL be verified by: bytes A2 00 00 00 20, slave returns 0x12345678 with ack -> we=0; response 5A 12 34 56 78.
REQ-028 SHALL be verified by: a read with the slave never acking, TIMEOUT=255 -> cyc drops after 255 cycles; response EE.
REQ-029 SHALL be verified by: bytes 00 FF 42 then A2 + 4 address bytes -> the first three bytes produce no response or bus activity; the read completes normally.
REQ-030 SHALL be verified by: m_axis_tready toggling randomly during a read response -> exactly 5 bytes, in order, with no duplicates, and tdata stable while stalled.
REQ-031 SHALL be verified by: i_rst pulsed during BUS state -> cyc/stb low immediately, no response byte, and a subsequent write succeeds.
